mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of cycles the RAM port is driven per access; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 req0, req1  input  1 each  access request from requester 0 (CPU) / requester 1 (program loader).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-006 addr0, addr1  input  8 each  RAM address.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 rdata  output  8  read data of the last completed read; valid while ackN is high.
REQ-010 ram_addr, ram_wdata  output  8 each  registered address/data to the RAM.
REQ-011 ram_we, ram_re  output  1 each  RAM write/read strobes.
REQ-012 ram_rdata  input  8  RAM read data, valid in the last ACCESS cycle.
REQ-013 owner  output  1  index of the requester currently or last granted.
REQ-014 busy  output  1  high in states ACCESS and DONE.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE; encoding free.
REQ-016 IDLE: if no reqN high, remain IDLE; all strobes and acks low.
REQ-017 IDLE with exactly one reqN high: at next edge grant N, latch addrN/wdataN/weN into ram_addr/ram_wdata/internal we, set owner = N, load wait counter with WAIT_CYCLES, go ACCESS.
REQ-018 IDLE with both req high: grant the requester not equal to last_grant (round robin); last_grant updates to the granted index at the grant edge.
REQ-019 ACCESS: ram_we = latched we, ram_re = not latched we, both held constant for exactly WAIT_CYCLES cycles; ram_addr/ram_wdata stable throughout.
REQ-020 ACCESS: counter decrements each edge; at the edge where counter == 1, capture ram_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
REQ-021 DONE: ack[owner] high for exactly one cycle, other ack low, ram_we/ram_re low; next edge go IDLE unconditionally.
REQ-022 Latency: req sampled high in IDLE cycle c -> ACCESS cycles c+1..c+WAIT_CYCLES -> ack in cycle c+WAIT_CYCLES+1 -> IDLE in cycle c+WAIT_CYCLES+2.
REQ-023 Requester holds reqN and its addr/data/we stable until ackN; it deasserts reqN in the cycle after ackN or issues a new request.
REQ-024 reqN high in IDLE in the cycle after its ack is a new request and arbitrated normally per REQ-018.
REQ-025 Non-granted requests are ignored, not queued; they are re-arbitrated in the next IDLE cycle.
REQ-026 reqN dropping during ACCESS does not abort; access completes and ack still pulses.
REQ-027 ack0 and ack1 are never high simultaneously; ram_we and ram_re never high simultaneously.
REQ-028 Address and data pass through unmodified; no arithmetic on them; 8-bit addresses cover 0x00..0xFF with no wrap logic.

Reset
REQ-029 reset low forces asynchronously: state IDLE, ack0/ack1 0, ram_we/ram_re 0, ram_addr/ram_wdata 0x00, rdata 0x00, owner 0, busy 0, counter 0, last_grant 1 (requester 0 wins first tie).
REQ-030 reset asserted mid-ACCESS aborts the access with no ack; after release the FSM starts in IDLE and samples requests at the first rising edge.

Verification
REQ-031 WAIT_CYCLES=1, req0 read addr 0x10, RAM returns 0xA5 -> ram_re high 1 cycle at ram_addr 0x10, ack0 in cycle c+2, rdata 0xA5, owner 0.
REQ-032 WAIT_CYCLES=3, req1 write 0x3C to 0x80 -> ram_we high 3 consecutive cycles, ram_wdata 0x3C, ack1 in cycle c+4, rdata unchanged.
REQ-033 req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1; no ack overlap; each access 3 cycles at WAIT_CYCLES=1.
REQ-034 reset pulsed low during ACCESS of a write -> ram_we drops immediately, no ack, all outputs at reset values; a fresh req0 after release completes normally.
REQ-035 req0 dropped mid-ACCESS (WAIT_CYCLES=2) -> access still completes, ack0 pulses once, FSM returns IDLE and stays there.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Each granted access drives the RAM for WAIT_CYCLES cycles, then pulses a one-cycle ack.
module mem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,      // active-low, asynchronous
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_we0,
   input  logic       i_we1,
   input  logic [7:0] i_addr0,
   input  logic [7:0] i_addr1,
   input  logic [7:0] i_wdata0,
   input  logic [7:0] i_wdata1,
   output logic       o_ack0,
   output logic       o_ack1,
   output logic [7:0] o_rdata,
   output logic [7:0] o_ram_addr,
   output logic [7:0] o_ram_wdata,
   output logic       o_ram_we,
   output logic       o_ram_re,
   input  logic [7:0] i_ram_rdata,
   output logic       o_owner,
   output logic       o_busy
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t        r_state,   w_state_nxt;
   logic [CW-1:0] r_cnt,     w_cnt_nxt;
   logic          r_we,      w_we_nxt;
   logic          r_last,    w_last_nxt;
   logic          r_owner,   w_owner_nxt;
   logic [AW-1:0] r_addr,    w_addr_nxt;
   logic [DW-1:0] r_wdata,   w_wdata_nxt;
   logic [DW-1:0] r_rdata,   w_rdata_nxt;
   logic          r_ram_we,  w_ram_we_nxt;
   logic          r_ram_re,  w_ram_re_nxt;
   logic          r_ack0,    w_ack0_nxt;
   logic          r_ack1,    w_ack1_nxt;
   logic          r_busy,    w_busy_nxt;

   logic          w_grant;
   logic          w_sel_we;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      w_grant  = (i_req0 & i_req1) ? ~r_last : i_req1;
      w_sel_we = w_grant ? i_we1 : i_we0;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_ram_we <= 1'b0;
         r_ram_re <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_we     <= w_we_nxt;
         r_last   <= w_last_nxt;
         r_owner  <= w_owner_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rdata  <= w_rdata_nxt;
         r_ram_we <= w_ram_we_nxt;
         r_ram_re <= w_ram_re_nxt;
         r_ack0   <= w_ack0_nxt;
         r_ack1   <= w_ack1_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // Next-state and next-output logic; strobes and acks are computed one cycle ahead.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_we_nxt     = r_we;
      w_last_nxt   = r_last;
      w_owner_nxt  = r_owner;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_rdata_nxt  = r_rdata;
      w_ram_we_nxt = 1'b0;
      w_ram_re_nxt = 1'b0;
      w_ack0_nxt   = 1'b0;
      w_ack1_nxt   = 1'b0;
      w_busy_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_req0 | i_req1) begin
               w_state_nxt  = ST_ACCESS;
               w_owner_nxt  = w_grant;
               w_last_nxt   = w_grant;
               w_we_nxt     = w_sel_we;
               w_addr_nxt   = w_grant ? i_addr1  : i_addr0;
               w_wdata_nxt  = w_grant ? i_wdata1 : i_wdata0;
               w_cnt_nxt    = CW'(WAIT_CYCLES);
               w_ram_we_nxt = w_sel_we;
               w_ram_re_nxt = ~w_sel_we;
               w_busy_nxt   = 1'b1;
            end
         end
         ST_ACCESS: begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = ST_DONE;
               if (!r_we) begin
                  w_rdata_nxt = i_ram_rdata;
               end
               w_ack0_nxt = ~r_owner;
               w_ack1_nxt = r_owner;
            end else begin
               w_ram_we_nxt = r_we;
               w_ram_re_nxt = ~r_we;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_ack0      = r_ack0;
   assign o_ack1      = r_ack1;
   assign o_rdata     = r_rdata;
   assign o_ram_addr  = r_addr;
   assign o_ram_wdata = r_wdata;
   assign o_ram_we    = r_ram_we;
   assign o_ram_re    = r_ram_re;
   assign o_owner     = r_owner;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_CYCLES 1..3) run directed and random
// traffic against a transaction-level model of the arbitration and access timing.
module tb_mem_arbiter;

   localparam int NCYC  = 400;
   localparam int RST_T = 51;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;
   int   n_done;
   logic [7:0] mem [256];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h10] = 8'hA5;
   end

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int WI = k + 1;

      logic       req0, req1, we0, we1;
      logic [7:0] addr0, addr1, wdata0, wdata1;
      logic       ack0, ack1, ram_we, ram_re, owner, busy;
      logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

      assign ram_rdata = ram_re ? mem[ram_addr] : 8'hEE;

      mem_arbiter #(.WAIT_CYCLES(WI)) u_dut (
         .i_clk       (clk),
         .i_reset     (rst_n),
         .i_req0      (req0),
         .i_req1      (req1),
         .i_we0       (we0),
         .i_we1       (we1),
         .i_addr0     (addr0),
         .i_addr1     (addr1),
         .i_wdata0    (wdata0),
         .i_wdata1    (wdata1),
         .o_ack0      (ack0),
         .o_ack1      (ack1),
         .o_rdata     (rdata),
         .o_ram_addr  (ram_addr),
         .o_ram_wdata (ram_wdata),
         .o_ram_we    (ram_we),
         .o_ram_re    (ram_re),
         .i_ram_rdata (ram_rdata),
         .o_owner     (owner),
         .o_busy      (busy)
      );

      // requester side
      bit         p_pend [2];
      logic       p_req  [2];
      logic       p_we   [2];
      logic [7:0] p_addr [2];
      logic [7:0] p_wd   [2];

      // model: one transaction record plus arbitration memory
      bit         m_act;
      int         m_s;
      bit         m_g, m_we, m_last, m_owner;
      logic [7:0] m_addr, m_wd, m_rdata;

      task automatic issue(input int r, input logic we, input logic [7:0] a, input logic [7:0] d);
         p_pend[r] = 1'b1;
         p_req[r]  = 1'b1;
         p_we[r]   = we;
         p_addr[r] = a;
         p_wd[r]   = d;
      endtask

      task automatic drive();
         req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
         req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
      endtask

      task automatic chk_reset_vals(input string pfx);
         chk($sformatf("%s ack0", pfx), 32'(ack0), 32'd0);
         chk($sformatf("%s ack1", pfx), 32'(ack1), 32'd0);
         chk($sformatf("%s ram_we", pfx), 32'(ram_we), 32'd0);
         chk($sformatf("%s ram_re", pfx), 32'(ram_re), 32'd0);
         chk($sformatf("%s busy", pfx), 32'(busy), 32'd0);
         chk($sformatf("%s owner", pfx), 32'(owner), 32'd0);
         chk($sformatf("%s rdata", pfx), 32'(rdata), 32'd0);
         chk($sformatf("%s ram_addr", pfx), 32'(ram_addr), 32'd0);
         chk($sformatf("%s ram_wdata", pfx), 32'(ram_wdata), 32'd0);
      endtask

      initial begin
         bit   g, e_acc, e_done, granted_acc;
         string pfx;
         for (int r = 0; r < 2; r++) begin
            p_pend[r] = 1'b0; p_req[r] = 1'b0; p_we[r] = 1'b0;
            p_addr[r] = 8'h00; p_wd[r] = 8'h00;
         end
         drive();
         m_act = 1'b0; m_s = 0; m_g = 1'b0; m_we = 1'b0; m_last = 1'b1;
         m_owner = 1'b0; m_addr = 8'h00; m_wd = 8'h00; m_rdata = 8'h00;

         #3;
         chk_reset_vals($sformatf("w%0d init", WI));
         wait (rst_n === 1'b1);

         for (int t = 1; t <= NCYC; t++) begin
            @(posedge clk);
            #1;
            pfx = $sformatf("w%0d t%0d", WI, t);

            if (t == RST_T + 1) begin
               // the preceding edge happened while reset was low
               m_act = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_rdata = 8'h00;
               for (int r = 0; r < 2; r++) begin
                  p_pend[r] = 1'b0; p_req[r] = 1'b0;
               end
               chk_reset_vals({pfx, " rst"});
            end else if (!(m_act && (t - 1) <= m_s + WI + 1) && (req0 || req1)) begin
               g = (req0 && req1) ? !m_last : req1;
               m_act   = 1'b1;
               m_s     = t - 1;
               m_g     = g;
               m_we    = g ? we1 : we0;
               m_addr  = g ? addr1 : addr0;
               m_wd    = g ? wdata1 : wdata0;
               m_last  = g;
               m_owner = g;
            end

            e_acc  = m_act && t >= m_s + 1 && t <= m_s + WI;
            e_done = m_act && t == m_s + WI + 1;
            if (e_done && !m_we) m_rdata = mem[m_addr];

            chk({pfx, " ack0"},   32'(ack0),   32'(e_done && !m_g));
            chk({pfx, " ack1"},   32'(ack1),   32'(e_done && m_g));
            chk({pfx, " ram_we"}, 32'(ram_we), 32'(e_acc && m_we));
            chk({pfx, " ram_re"}, 32'(ram_re), 32'(e_acc && !m_we));
            chk({pfx, " busy"},   32'(busy),   32'(e_acc || e_done));
            chk({pfx, " owner"},  32'(owner),  32'(m_owner));
            chk({pfx, " rdata"},  32'(rdata),  32'(m_rdata));
            if (e_acc) begin
               chk({pfx, " ram_addr"},  32'(ram_addr),  32'(m_addr));
               chk({pfx, " ram_wdata"}, 32'(ram_wdata), 32'(m_wd));
            end

            for (int r = 0; r < 2; r++) begin
               if (p_pend[r] && e_done && int'(m_g) == r) p_pend[r] = 1'b0;
               if (!p_pend[r]) begin
                  p_req[r]  = 1'b0;
                  p_we[r]   = 1'($urandom);
                  p_addr[r] = 8'($urandom);
                  p_wd[r]   = 8'($urandom);
               end
               granted_acc = e_acc && int'(m_g) == r;
               if (t >= 20 && t <= 31 && !p_pend[r])
                  issue(r, 1'($urandom), 8'($urandom), 8'($urandom));
               if (t > 60 && t < 70 && granted_acc)
                  p_req[r] = 1'b0;
               if (t >= 70 && t < NCYC - 20) begin
                  if (!p_pend[r] && $urandom_range(0, 2) == 0)
                     issue(r, 1'($urandom), 8'($urandom), 8'($urandom));
                  else if (granted_acc && $urandom_range(0, 3) == 0)
                     p_req[r] = 1'b0;
               end
            end
            if (t == 1)         issue(0, 1'b0, 8'h10, 8'h00);
            if (t == 8)         issue(1, 1'b1, 8'h80, 8'h3C);
            if (t == 50)        issue(0, 1'b1, 8'h22, 8'h77);
            if (t == RST_T + 1) issue(0, 1'b0, 8'h55, 8'h00);
            if (t == 60)        issue(0, 1'b0, 8'h10, 8'h00);
            drive();

            if (t == RST_T) begin
               #5;
               chk_reset_vals({pfx, " async"});
            end
         end
         n_done++;
      end
   end

   initial begin
      n_chk  = 0;
      n_bad  = 0;
      n_done = 0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (RST_T) @(posedge clk);
      #4 rst_n = 1'b0;
      @(posedge clk);
      #4 rst_n = 1'b1;
      repeat (NCYC - RST_T + 3) @(posedge clk);
      #3;
      chk("all_done", 32'(n_done), 32'd3);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
